// File: rtl/run_controller_if.sv
// rtl/run_controller_if.sv - control/status bundle between a run master and the run controller
interface run_controller_if #(
    parameter int CW = 16
) ();
    logic          start;
    logic          core_done;
    logic          core_reset;
    logic          busy;
    logic          finished;
    logic          timeout;
    logic [CW-1:0] cycle_count;
    logic [7:0]    run_count;

    modport master (
        output start, core_done,
        input  core_reset, busy, finished, timeout, cycle_count, run_count
    );

    modport slave (
        input  start, core_done,
        output core_reset, busy, finished, timeout, cycle_count, run_count
    );
endinterface

// File: rtl/run_controller.sv
// rtl/run_controller.sv - sequences core reset, run supervision with timeout, and run bookkeeping
module run_controller #(
    parameter int RST_CYCLES = 4,
    parameter int CW         = 16,
    parameter int MAX_CYCLES = 50000
) (
    input  logic           clk,
    input  logic           rst,
    run_controller_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam logic [7:0]    HOLD_INIT = 8'(RST_CYCLES);
    localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_CYCLES);
    localparam logic [CW-1:0] CC_ONE    = CW'(1);

    state_t        state_q, state_d;
    logic [7:0]    hold_cnt_q, hold_cnt_d;
    logic [CW-1:0] cycle_count_q, cycle_count_d;
    logic [CW-1:0] cycle_inc;
    logic [7:0]    run_count_q, run_count_d;
    logic          timeout_q, timeout_d;
    logic          core_reset_q, core_reset_d;
    logic          busy_q, busy_d;
    logic          finished_q, finished_d;

    assign cycle_inc = cycle_count_q + CC_ONE;

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        cycle_count_d = cycle_count_q;
        run_count_d   = run_count_q;
        timeout_d     = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d       = ST_HOLD;
                    hold_cnt_d    = HOLD_INIT;
                    cycle_count_d = '0;
                    timeout_d     = 1'b0;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q <= 8'd1) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end
            ST_RUN: begin
                // Counted even on the exit cycle, so a timeout leaves the count at MAX_CYCLES.
                cycle_count_d = cycle_inc;
                if (bus.core_done) begin
                    state_d = ST_FIN;
                end else if (cycle_inc == MAX_CNT) begin
                    state_d   = ST_FIN;
                    timeout_d = 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                if (run_count_q != 8'hFF) begin
                    run_count_d = run_count_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        core_reset_d = (state_d != ST_RUN);
        busy_d       = (state_d != ST_IDLE);
        finished_d   = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            hold_cnt_q    <= 8'd0;
            cycle_count_q <= '0;
            run_count_q   <= 8'd0;
            timeout_q     <= 1'b0;
            core_reset_q  <= 1'b1;
            busy_q        <= 1'b0;
            finished_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            cycle_count_q <= cycle_count_d;
            run_count_q   <= run_count_d;
            timeout_q     <= timeout_d;
            core_reset_q  <= core_reset_d;
            busy_q        <= busy_d;
            finished_q    <= finished_d;
        end
    end

    assign bus.core_reset  = core_reset_q;
    assign bus.busy        = busy_q;
    assign bus.finished    = finished_q;
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cycle_count_q;
    assign bus.run_count   = run_count_q;
endmodule

// File: tb/tb_run_controller.sv
// tb/tb_run_controller.sv - directed table-driven bench for run_controller (RST_CYCLES=4, MAX_CYCLES=20)
module tb_run_controller;
    logic clk;
    logic rst;

    run_controller_if #(.CW(16)) bus ();

    run_controller #(
        .RST_CYCLES(4),
        .CW        (16),
        .MAX_CYCLES(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        done;
        logic        cr;
        logic        busy;
        logic        fin;
        logic        to;
        logic [15:0] cc;
        logic [7:0]  rc;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_bad;

    function automatic void add(bit s, bit d, bit cr, bit b, bit f, bit t, int cc, int rc);
        vec_t v;
        v.start = s;
        v.done  = d;
        v.cr    = cr;
        v.busy  = b;
        v.fin   = f;
        v.to    = t;
        v.cc    = 16'(cc);
        v.rc    = 8'(rc);
        vecs.push_back(v);
    endfunction

    // One complete run: done_at = RUN cycle carrying Core_Done (0 = never), pk = poke ignored inputs.
    function automatic void add_run(int done_at, int rc0, bit pk);
        int n;
        bit t;
        int rc1;
        n   = (done_at == 0) ? 20 : done_at;
        t   = (done_at == 0);
        rc1 = (rc0 < 255) ? rc0 + 1 : 255;
        add(1, 0, 1, 1, 0, 0, 0, rc0);
        for (int i = 1; i <= 3; i++) add(pk, pk, 1, 1, 0, 0, 0, rc0);
        add(0, pk, 0, 1, 0, 0, 0, rc0);
        for (int k = 1; k <= n; k++) begin
            if (k < n) add(pk && (k == 3), k == done_at, 0, 1, 0, 0, k, rc0);
            else       add(pk && (k == 3), k == done_at, 1, 1, 1, t, k, rc0);
        end
        add(pk, 0, 1, 0, 0, t, n, rc1);
        add(0, 0, 1, 0, 0, t, n, rc1);
    endfunction

    task automatic check_outs(input string name, input bit cr, input bit b, input bit f,
                              input bit t, input int cc, input int rc);
        n_vec++;
        if (bus.core_reset !== cr || bus.busy !== b || bus.finished !== f ||
            bus.timeout !== t || bus.cycle_count !== 16'(cc) || bus.run_count !== 8'(rc)) begin
            n_bad++;
            $display("FAIL %s: got cr=%0b busy=%0b fin=%0b to=%0b cc=%0d rc=%0d, want cr=%0b busy=%0b fin=%0b to=%0b cc=%0d rc=%0d",
                     name, bus.core_reset, bus.busy, bus.finished, bus.timeout,
                     bus.cycle_count, bus.run_count, cr, b, f, t, cc, rc);
        end
    endtask

    task automatic step(input bit s, input bit d);
        bus.start     = s;
        bus.core_done = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_rc;
        int waited;
        bit got_fin;

        n_vec = 0;
        n_bad = 0;
        bus.start     = 1'b0;
        bus.core_done = 1'b0;
        rst = 1'b1;

        #1;
        check_outs("reset_async", 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_outs("reset_held", 1, 0, 0, 0, 0, 0);
        rst = 1'b0;

        add_run(10, 0, 0);
        add_run(0, 1, 0);
        add_run(20, 2, 0);
        add_run(7, 3, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].start, vecs[i].done);
            check_outs($sformatf("vec%0d", i), vecs[i].cr, vecs[i].busy, vecs[i].fin,
                       vecs[i].to, vecs[i].cc, vecs[i].rc);
        end

        // Reset during RUN cycle 5 aborts the run immediately.
        step(1, 0);
        for (int i = 0; i < 4; i++) step(0, 0);
        for (int i = 0; i < 4; i++) step(0, 0);
        check_outs("mid_run_cc4", 0, 1, 0, 0, 4, 4);
        #2;
        rst = 1'b1;
        #1;
        check_outs("mid_run_reset_async", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0);
            check_outs($sformatf("mid_run_reset_hold%0d", i), 1, 0, 0, 0, 0, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(0, 1);
            check_outs($sformatf("post_reset_idle%0d", i), 1, 0, 0, 0, 0, 0);
        end

        // Start held high: 300 back-to-back one-cycle runs, one IDLE cycle between them.
        for (int r = 1; r <= 300; r++) begin
            got_fin = 1'b0;
            waited  = 0;
            while (!got_fin && waited < 12) begin
                step(1, 1);
                waited++;
                got_fin = bus.finished;
            end
            if (!got_fin) begin
                n_vec++;
                n_bad++;
                $display("FAIL b2b_wait_fin run %0d: no finished pulse within 12 cycles", r);
                break;
            end
            exp_rc = (r < 255) ? r : 255;
            step(1, 1);
            check_outs($sformatf("b2b_idle%0d", r), 1, 0, 0, 0, 1, exp_rc);
            step(1, 1);
            check_outs($sformatf("b2b_hold%0d", r), 1, 1, 0, 0, 0, exp_rc);
        end
        bus.start     = 1'b0;
        bus.core_done = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameter RST_CYCLES, default 4: number of cycles Core_Reset is held high after a Start before the core runs; legal range 1..255.
REQ-002 Parameter CW, default 16: width of Cycle_Count.
REQ-003 Parameter MAX_CYCLES, default 50000: RUN-cycle limit before timeout; legal range 1..2^CW-1.
REQ-004 Clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 Start  in  1  request to launch one program run; level-sampled each cycle.
REQ-007 Core_Done  in  1  done flag from the processor core.
REQ-008 Core_Reset  out  1  reset to the processor core; active-high.
REQ-009 Busy  out  1  high whenever the state is not IDLE.
REQ-010 Finished  out  1  one-cycle pulse at the end of each run.
REQ-011 Timeout  out  1  sticky flag set when a run hits MAX_CYCLES without Core_Done.
REQ-012 Cycle_Count  out  CW  number of RUN cycles in the current or most recent run.
REQ-013 Run_Count  out  8  number of completed runs, including timed-out runs.

Function
REQ-014 The block SHALL implement a four-state FSM: IDLE, HOLD, RUN, FIN.
REQ-015 Every output SHALL be driven from a register; there are no combinational input-to-output paths.
REQ-016 IDLE SHALL hold Core_Reset=1, Busy=0, Finished=0.
- Start=1 in IDLE SHALL transition to HOLD on the next edge.
- On that edge: clear Cycle_Count to 0, clear Timeout to 0, load the hold counter with RST_CYCLES.
REQ-017 HOLD SHALL keep Core_Reset=1 for exactly RST_CYCLES cycles, then transition to RUN; Core_Done SHALL be ignored in HOLD.
REQ-018 RUN SHALL drive Core_Reset=0 and increment Cycle_Count by 1 on every RUN cycle, including the cycle in which the exit condition is sampled.
REQ-019 In RUN, Core_Done=1 SHALL transition to FIN with Timeout=0.
REQ-020 In RUN, Core_Done=0 while Cycle_Count+1 equals MAX_CYCLES SHALL transition to FIN with Timeout=1; Cycle_Count SHALL then equal MAX_CYCLES.
REQ-021 If Core_Done=1 and the MAX_CYCLES limit occur in the same cycle, Core_Done SHALL win and Timeout SHALL stay 0.
REQ-022 FIN SHALL last exactly one cycle.
- Outputs in FIN: Finished=1, Core_Reset=1, Busy=1.
- On exit: Run_Count increments, saturating at 255; the next state is IDLE.
REQ-023 Start SHALL be ignored in HOLD, RUN and FIN; it does not queue.
REQ-024 If Start is held high continuously, a new run SHALL begin on the first IDLE cycle after FIN.
REQ-025 Cycle_Count and Timeout SHALL hold their values from FIN until the next accepted Start.
REQ-026 Cycle_Count SHALL never wrap, because MAX_CYCLES < 2^CW bounds it.
REQ-027 From accepted Start to the first RUN cycle, latency SHALL be RST_CYCLES+1 cycles.

Reset
REQ-028 Reset=1 SHALL asynchronously force the following values, and they SHALL hold while Reset is high:
- state=IDLE
- Core_Reset=1
- Busy=0, Finished=0, Timeout=0
- Cycle_Count=0, Run_Count=0
REQ-029 Reset asserted mid-run (any state) SHALL abort the run with no Finished pulse and no Run_Count update.
REQ-030 After Reset deasserts, the block SHALL wait in IDLE for Start.

Verification
REQ-031 A bench SHALL cover at least the following directed scenarios (default parameters):
- Normal run: Start pulse; Core_Done rises on the 10th RUN cycle -> Core_Reset high 4 cycles after Start, then low; Finished pulse; Cycle_Count=10; Timeout=0; Run_Count=1.
- Timeout: MAX_CYCLES=20, Core_Done held 0 -> FIN after 20 RUN cycles; Cycle_Count=20; Timeout=1; next Start clears Timeout to 0.
- Simultaneous events: MAX_CYCLES=20, Core_Done=1 on RUN cycle 20 -> Timeout=0, Cycle_Count=20.
- Ignored inputs: Start pulsed during HOLD and RUN -> no restart, one Finished pulse only; Core_Done=1 during HOLD -> ignored, core still enters RUN.
- Reset mid-RUN: Reset asserted at RUN cycle 5 -> Core_Reset=1 immediately (asynchronous); Run_Count=0; no Finished pulse.
- Back-to-back and saturation: Start held high for 300 runs -> each run separated by a single IDLE cycle; Run_Count saturates at 255.
